// File: rtl/req_gnt_pkg.sv
// Shared types, parameter limits and width helper for the request/grant arbiter.
package req_gnt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } arb_state_e;

    localparam int NUM_CH_MIN    = 1;
    localparam int NUM_CH_MAX    = 16;
    localparam int GNT_DELAY_MIN = 1;
    localparam int GNT_DELAY_MAX = 15;
    localparam int MAX_HOLD_MIN  = 1;
    localparam int MAX_HOLD_MAX  = 255;

    // Index width that stays at least one bit wide even for a single channel.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo NUM_CH.
module rr_pick
    import req_gnt_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [idx_w(NUM_CH)-1:0]  ptr,
    output logic [idx_w(NUM_CH)-1:0]  idx,
    output logic                      valid
);

    localparam int IW = idx_w(NUM_CH);

    logic [NUM_CH-1:0] hit;
    logic [IW-1:0]     cand [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
        logic [IW:0] sum;
        assign sum       = {1'b0, ptr} + (IW+1)'(gi);
        assign cand[gi]  = (sum >= (IW+1)'(NUM_CH)) ? IW'(sum - (IW+1)'(NUM_CH)) : sum[IW-1:0];
        assign hit[gi]   = req[cand[gi]];
    end

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx   = cand[i];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_gnt_arbiter.sv
// Multi-channel request/grant arbiter: round-robin winner selection, programmable
// grant latency and a bounded hold time that force-releases a greedy winner.
module req_gnt_arbiter
    import req_gnt_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int GNT_DELAY = 1,
    parameter int MAX_HOLD  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         req,
    output logic [NUM_CH-1:0]         gnt,
    output logic [idx_w(NUM_CH)-1:0]  gnt_id,
    output logic                      busy,
    output logic                      hold_err
);

    localparam int IW = idx_w(NUM_CH);

    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
        $error("req_gnt_arbiter: NUM_CH out of range");
    end
    if (GNT_DELAY < GNT_DELAY_MIN || GNT_DELAY > GNT_DELAY_MAX) begin : g_bad_delay
        $error("req_gnt_arbiter: GNT_DELAY out of range");
    end
    if (MAX_HOLD < MAX_HOLD_MIN || MAX_HOLD > MAX_HOLD_MAX) begin : g_bad_hold
        $error("req_gnt_arbiter: MAX_HOLD out of range");
    end

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      winner_q, winner_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [3:0]         dly_cnt_q, dly_cnt_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic [NUM_CH-1:0]  gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               hold_err_q, hold_err_d;

    logic [IW-1:0]      pick_idx;
    logic               pick_valid;
    logic [IW-1:0]      ptr_next;

    rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign ptr_next = (winner_q == IW'(NUM_CH - 1)) ? '0 : winner_q + IW'(1);

    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        ptr_d      = ptr_q;
        dly_cnt_d  = dly_cnt_q;
        hold_cnt_d = hold_cnt_q;
        hold_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    winner_d   = pick_idx;
                    hold_cnt_d = '0;
                    if (GNT_DELAY == 1) begin
                        state_d = GRANT;
                    end else begin
                        state_d   = WAIT;
                        dly_cnt_d = 4'(GNT_DELAY - 1);
                    end
                end
            end
            WAIT: begin
                // A withdrawn request aborts without touching ptr.
                if (!req[winner_q]) begin
                    state_d   = IDLE;
                    dly_cnt_d = '0;
                end else if (dly_cnt_q <= 4'd1) begin
                    state_d   = GRANT;
                    dly_cnt_d = '0;
                end else begin
                    dly_cnt_d = dly_cnt_q - 4'd1;
                end
            end
            GRANT: begin
                // Release takes priority over the hold limit, so no hold_err then.
                if (!req[winner_q]) begin
                    state_d    = IDLE;
                    ptr_d      = ptr_next;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == 8'(MAX_HOLD - 1)) begin
                    state_d    = IDLE;
                    ptr_d      = ptr_next;
                    hold_cnt_d = '0;
                    hold_err_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_d = '0;
        if (state_d == GRANT) begin
            gnt_d[winner_d] = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            winner_q   <= '0;
            ptr_q      <= '0;
            dly_cnt_q  <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            hold_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            winner_q   <= winner_d;
            ptr_q      <= ptr_d;
            dly_cnt_q  <= dly_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            hold_err_q <= hold_err_d;
        end
    end

    assign gnt      = gnt_q;
    assign gnt_id   = winner_q;
    assign busy     = busy_q;
    assign hold_err = hold_err_q;

`ifndef SYNTHESIS
    // Request history: entry i holds req as sampled i+1 edges ago.
    logic [NUM_CH-1:0] req_hist_q [GNT_DELAY];
    logic              hist_ok;

    always_ff @(posedge clk) begin
        req_hist_q[0] <= req;
        for (int i = 1; i < GNT_DELAY; i++) begin
            req_hist_q[i] <= req_hist_q[i-1];
        end
    end

    always_comb begin
        hist_ok = 1'b1;
        for (int i = 0; i < GNT_DELAY; i++) begin
            hist_ok = hist_ok & req_hist_q[i][gnt_id];
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_has_req: assert property (@(posedge clk) disable iff (rst) $rose(|gnt) |-> hist_ok);
    a_hold_bound:  assert property (@(posedge clk) disable iff (rst)
                                    (state_q == GRANT) |-> (hold_cnt_q < 8'(MAX_HOLD)));

    if (GNT_DELAY == 1) begin : g_fast_latency
        a_req_to_gnt: assert property (@(posedge clk) disable iff (rst)
                                       (state_q == IDLE && (|req)) |=> (|gnt));
    end
`endif

endmodule

// File: tb/tb_req_gnt_arbiter.sv
// Directed bench for req_gnt_arbiter: three configurations exercised one scenario at a time.
module tb_req_gnt_arbiter;

    logic       clk;
    logic       rst;

    logic       req1, gnt1, gnt_id1, busy1, herr1;
    logic [3:0] req4, gnt4;
    logic [1:0] gnt_id4;
    logic       busy4, herr4;
    logic [2:0] req3, gnt3;
    logic [1:0] gnt_id3;
    logic       busy3, herr3;

    int checks = 0;
    int errors = 0;

    req_gnt_arbiter #(.NUM_CH(1), .GNT_DELAY(1), .MAX_HOLD(8)) u1 (
        .clk(clk), .rst(rst), .req(req1), .gnt(gnt1),
        .gnt_id(gnt_id1), .busy(busy1), .hold_err(herr1)
    );

    req_gnt_arbiter #(.NUM_CH(4), .GNT_DELAY(3), .MAX_HOLD(4)) u4 (
        .clk(clk), .rst(rst), .req(req4), .gnt(gnt4),
        .gnt_id(gnt_id4), .busy(busy4), .hold_err(herr4)
    );

    req_gnt_arbiter #(.NUM_CH(3), .GNT_DELAY(4), .MAX_HOLD(16)) u3 (
        .clk(clk), .rst(rst), .req(req3), .gnt(gnt3),
        .gnt_id(gnt_id3), .busy(busy3), .hold_err(herr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req1 = 1'b0; req4 = '0; req3 = '0;
        step(2);
        checks++; if (gnt4 !== 4'b0000) begin errors++; $display("FAIL reset_gnt4: got %b expected %b", gnt4, 4'b0000); end
        checks++; if (gnt_id4 !== 2'd0) begin errors++; $display("FAIL reset_gnt_id4: got %0d expected 0", gnt_id4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4: got %b expected 0", busy4); end
        checks++; if (herr4 !== 1'b0) begin errors++; $display("FAIL reset_herr4: got %b expected 0", herr4); end
        checks++; if (gnt3 !== 3'b000) begin errors++; $display("FAIL reset_gnt3: got %b expected 000", gnt3); end
        checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt1: got %b expected 0", gnt1); end
        rst = 1'b0;
        step(1);
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL post_reset_busy4: got %b expected 0", busy4); end
        $display("test_reset done");
    endtask

    task automatic test_single_channel();
        req1 = 1'b1;
        step(1);
        checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL single_gnt_rise: got %b expected 1", gnt1); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy1); end
        for (int i = 0; i < 4; i++) begin
            step(1);
            checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL single_gnt_hold%0d: got %b expected 1", i, gnt1); end
        end
        req1 = 1'b0;
        step(1);
        checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL single_gnt_fall: got %b expected 0", gnt1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b expected 0", busy1); end
        checks++; if (herr1 !== 1'b0) begin errors++; $display("FAIL single_herr: got %b expected 0", herr1); end
        $display("test_single_channel done");
    endtask

    task automatic test_round_robin_delay();
        req4 = 4'b0110;
        step(1);
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL rr_wait_busy: got %b expected 1", busy4); end
        checks++; if (gnt_id4 !== 2'd1) begin errors++; $display("FAIL rr_first_id: got %0d expected 1", gnt_id4); end
        checks++; if (gnt4 !== 4'b0000) begin errors++; $display("FAIL rr_wait_gnt0: got %b expected 0000", gnt4); end
        step(1);
        checks++; if (gnt4 !== 4'b0000) begin errors++; $display("FAIL rr_wait_gnt1: got %b expected 0000", gnt4); end
        step(1);
        checks++; if (gnt4 !== 4'b0010) begin errors++; $display("FAIL rr_ch1_gnt: got %b expected 0010", gnt4); end
        req4 = 4'b0100;
        step(1);
        checks++; if (gnt4 !== 4'b0000) begin errors++; $display("FAIL rr_ch1_release: got %b expected 0000", gnt4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rr_idle_gap: got %b expected 0", busy4); end
        req4 = 4'b0110;
        step(1);
        checks++; if (gnt_id4 !== 2'd2) begin errors++; $display("FAIL rr_second_id: got %0d expected 2", gnt_id4); end
        step(2);
        checks++; if (gnt4 !== 4'b0100) begin errors++; $display("FAIL rr_ch2_gnt: got %b expected 0100", gnt4); end
        req4 = 4'b0010;
        step(1);
        checks++; if (gnt4 !== 4'b0000) begin errors++; $display("FAIL rr_ch2_release: got %b expected 0000", gnt4); end
        checks++; if (herr4 !== 1'b0) begin errors++; $display("FAIL rr_release_herr: got %b expected 0", herr4); end
        step(1);
        checks++; if (gnt_id4 !== 2'd1) begin errors++; $display("FAIL rr_third_id: got %0d expected 1", gnt_id4); end
        req4 = 4'b0000;
        step(1);
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rr_abort_busy: got %b expected 0", busy4); end
        $display("test_round_robin_delay done");
    endtask

    task automatic test_max_hold();
        req4 = 4'b0001;
        step(3);
        checks++; if (gnt4 !== 4'b0001) begin errors++; $display("FAIL hold_gnt_start: got %b expected 0001", gnt4); end
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++; if (gnt4 !== 4'b0001 || herr4 !== 1'b0) begin errors++; $display("FAIL hold_cycle%0d: got gnt=%b herr=%b expected gnt=0001 herr=0", i, gnt4, herr4); end
        end
        step(1);
        checks++; if (gnt4 !== 4'b0000) begin errors++; $display("FAIL hold_force_release: got %b expected 0000", gnt4); end
        checks++; if (herr4 !== 1'b1) begin errors++; $display("FAIL hold_err_pulse: got %b expected 1", herr4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL hold_idle_gap: got %b expected 0", busy4); end
        step(1);
        checks++; if (herr4 !== 1'b0) begin errors++; $display("FAIL hold_err_width: got %b expected 0", herr4); end
        checks++; if (busy4 !== 1'b1 || gnt_id4 !== 2'd0) begin errors++; $display("FAIL hold_rearb: got busy=%b id=%0d expected busy=1 id=0", busy4, gnt_id4); end
        step(2);
        checks++; if (gnt4 !== 4'b0001) begin errors++; $display("FAIL hold_regrant: got %b expected 0001", gnt4); end
        req4 = 4'b0000;
        step(1);
        checks++; if (gnt4 !== 4'b0000) begin errors++; $display("FAIL hold_final_release: got %b expected 0000", gnt4); end
        $display("test_max_hold done");
    endtask

    task automatic test_release_at_max_hold();
        req4 = 4'b0001;
        step(3);
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++; if (gnt4 !== 4'b0001) begin errors++; $display("FAIL relmax_cycle%0d: got %b expected 0001", i, gnt4); end
        end
        req4 = 4'b0000;
        step(1);
        checks++; if (gnt4 !== 4'b0000) begin errors++; $display("FAIL relmax_gnt: got %b expected 0000", gnt4); end
        checks++; if (herr4 !== 1'b0) begin errors++; $display("FAIL relmax_herr: got %b expected 0", herr4); end
        $display("test_release_at_max_hold done");
    endtask

    task automatic test_async_reset();
        req4 = 4'b0100;
        step(3);
        checks++; if (gnt4 !== 4'b0100) begin errors++; $display("FAIL areset_pre_gnt: got %b expected 0100", gnt4); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (gnt4 !== 4'b0000) begin errors++; $display("FAIL areset_gnt_immediate: got %b expected 0000", gnt4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL areset_busy_immediate: got %b expected 0", busy4); end
        req4 = 4'b0011;
        step(1);
        rst = 1'b0;
        step(1);
        checks++; if (busy4 !== 1'b1 || gnt_id4 !== 2'd0) begin errors++; $display("FAIL areset_rearb_from0: got busy=%b id=%0d expected busy=1 id=0", busy4, gnt_id4); end
        req4 = 4'b0000;
        step(1);
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL areset_abort: got %b expected 0", busy4); end
        $display("test_async_reset done");
    endtask

    task automatic test_rr_wrap();
        int          order [4] = '{0, 1, 2, 0};
        logic [2:0]  exp_g;
        for (int r = 0; r < 4; r++) begin
            exp_g = 3'b001 << order[r];
            req3 = 3'b111;
            step(1);
            checks++; if (gnt_id3 !== 2'(order[r]) || busy3 !== 1'b1) begin errors++; $display("FAIL wrap_id_r%0d: got id=%0d busy=%b expected id=%0d busy=1", r, gnt_id3, busy3, order[r]); end
            step(3);
            checks++; if (gnt3 !== exp_g) begin errors++; $display("FAIL wrap_gnt_r%0d: got %b expected %b", r, gnt3, exp_g); end
            step(9);
            checks++; if (gnt3 !== exp_g) begin errors++; $display("FAIL wrap_hold_r%0d: got %b expected %b", r, gnt3, exp_g); end
            req3 = 3'b111 & ~exp_g;
            step(1);
            checks++; if (gnt3 !== 3'b000) begin errors++; $display("FAIL wrap_release_r%0d: got %b expected 000", r, gnt3); end
            $display("wrap round %0d granted ch%0d", r, order[r]);
        end
        req3 = 3'b000;
        step(1);
    endtask

    task automatic test_wait_abort();
        req3 = 3'b100;
        step(1);
        checks++; if (busy3 !== 1'b1 || gnt_id3 !== 2'd2) begin errors++; $display("FAIL abort_wait_entry: got busy=%b id=%0d expected busy=1 id=2", busy3, gnt_id3); end
        step(1);
        checks++; if (gnt3 !== 3'b000) begin errors++; $display("FAIL abort_wait_gnt: got %b expected 000", gnt3); end
        req3 = 3'b000;
        step(1);
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL abort_to_idle: got %b expected 0", busy3); end
        step(3);
        checks++; if (gnt3 !== 3'b000) begin errors++; $display("FAIL abort_no_gnt: got %b expected 000", gnt3); end
        req3 = 3'b101;
        step(1);
        checks++; if (gnt_id3 !== 2'd2) begin errors++; $display("FAIL abort_ptr_kept: got id=%0d expected 2", gnt_id3); end
        req3 = 3'b000;
        step(1);
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL abort_final_idle: got %b expected 0", busy3); end
        $display("test_wait_abort done");
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin_delay();
        test_max_hold();
        test_release_at_max_hold();
        test_async_reset();
        test_rr_wrap();
        test_wait_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
